// File: rtl/mdu_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sched_if
//  Description : Pipeline <-> MDU sequencer signal bundle. The master side
//                is the E/D pipeline logic; the slave side is mdu_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdu_sched_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] wdata;
    logic        flush;
    logic        md_use_d;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;

    modport master (
        output start, op, a, b, mt_hi, mt_lo, wdata, flush, md_use_d,
        input  busy, stall, hi, lo, done
    );

    modport slave (
        input  start, op, a, b, mt_hi, mt_lo, wdata, flush, md_use_d,
        output busy, stall, hi, lo, done
    );
endinterface
`default_nettype wire

// File: rtl/mdu_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sched
//  Description : E-stage multiply/divide sequencer. Latches operands on an
//                accepted op, counts a fixed latency, then commits HI/LO.
//                Generates the D-stage stall for HI/LO users and honours the
//                exception flush for ops that have not yet started.
//                Optional macro MDU_MADD_EN enables madd/maddu (ops 4/5).
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_sched #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  wire logic   clk,
    input  wire logic   reset,
    mdu_sched_if.slave  bus
);

    localparam int c_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int c_CNT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [2:0]          r_op;
    logic [31:0]         r_a, r_b;
    logic [31:0]         r_hi, r_lo, w_hi_nxt, w_lo_nxt;

    logic                w_op_valid, w_is_div, w_accept, w_mt_ok, w_commit;
    logic [63:0]         w_prod_s, w_prod_u;
    logic                w_div_zero, w_div_ovf;
    logic [31:0]         w_div_b_u;
    logic signed [31:0]  w_sdiv_a, w_sdiv_b, w_sq, w_sr;
    logic [31:0]         w_uq, w_ur;

    // Decode which op codes are real MDU ops in this build
    always_comb begin
`ifdef MDU_MADD_EN
        w_op_valid = (bus.op <= 3'd5);
`else
        w_op_valid = (bus.op <= 3'd3);
`endif
        w_is_div = (bus.op == 3'd2) || (bus.op == 3'd3);
    end

    // A start beats a same-cycle mthi/mtlo; flush suppresses both
    assign w_accept = (r_state == ST_IDLE) & bus.start & ~bus.flush & w_op_valid;
    assign w_mt_ok  = (r_state == ST_IDLE) & ~bus.flush & ~w_accept;
    assign w_commit = (r_state == ST_RUN) & (r_cnt == '0);

    // Product: sign/zero extend to 64 bits so the low 64 bits are exact
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Divisor is forced to 1 on the cases whose result is overridden, so the
    // divider never sees divide-by-zero or the signed overflow case
    assign w_div_zero = (r_b == 32'd0);
    assign w_div_ovf  = (r_a == 32'h8000_0000) & (r_b == 32'hFFFF_FFFF);
    assign w_div_b_u  = w_div_zero ? 32'd1 : r_b;
    assign w_sdiv_a   = r_a;
    assign w_sdiv_b   = (w_div_zero | w_div_ovf) ? 32'sd1 : r_b;
    assign w_sq       = w_sdiv_a / w_sdiv_b;
    assign w_sr       = w_sdiv_a % w_sdiv_b;
    assign w_uq       = r_a / w_div_b_u;
    assign w_ur       = r_a % w_div_b_u;

    // HI/LO next value: commit result, else mthi/mtlo in IDLE
    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (w_commit) begin
            case (r_op)
                3'd0: {w_hi_nxt, w_lo_nxt} = w_prod_s;
                3'd1: {w_hi_nxt, w_lo_nxt} = w_prod_u;
                3'd2: begin
                    if (w_div_ovf) begin
                        w_lo_nxt = 32'h8000_0000;
                        w_hi_nxt = 32'd0;
                    end else if (!w_div_zero) begin
                        w_lo_nxt = w_sq;
                        w_hi_nxt = w_sr;
                    end
                end
                3'd3: begin
                    if (!w_div_zero) begin
                        w_lo_nxt = w_uq;
                        w_hi_nxt = w_ur;
                    end
                end
`ifdef MDU_MADD_EN
                3'd4: {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} + w_prod_s;
                3'd5: {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} + w_prod_u;
`endif
                default: ;
            endcase
        end else if (w_mt_ok) begin
            if (bus.mt_hi) w_hi_nxt = bus.wdata;
            if (bus.mt_lo) w_lo_nxt = bus.wdata;
        end
    end

    // Next-state and latency counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = w_is_div ? c_CNT_W'(DIV_LAT - 1)
                                           : c_CNT_W'(MULT_LAT - 1);
                end
            end
            ST_RUN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, counter, operand latches and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (w_accept) begin
                r_op <= bus.op;
                r_a  <= bus.a;
                r_b  <= bus.b;
            end
        end
    end

    assign bus.busy  = (r_state == ST_RUN);
    assign bus.done  = w_commit;
    assign bus.stall = bus.md_use_d &
                       ((r_state == ST_RUN) | (bus.start & ~bus.flush & w_op_valid));
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_sched
//  Description : Self-checking bench for mdu_sched: table of arithmetic
//                vectors plus hand-written flush/reset/mt/stall sequences,
//                with HI/LO results checked through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_sched;

    localparam int c_MLAT = 5;
    localparam int c_DLAT = 10;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    mdu_sched_if bus ();

    mdu_sched #(.MULT_LAT(c_MLAT), .DIV_LAT(c_DLAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] sb[$];
    vec_t        vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] d);
        bus.mt_hi = h; bus.mt_lo = l; bus.wdata = d;
        tick();
        bus.mt_hi = 1'b0; bus.mt_lo = 1'b0;
    endtask

    // Issue one op and follow it to commit; expected HI/LO go via the scoreboard
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic md_use, input bit flush_mid,
                          input bit mt_mid, input bit mt_start,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int busy_cnt, done_at, stall_bad;
        logic [63:0] exp;
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1; bus.md_use_d = md_use;
        if (mt_start) begin
            bus.mt_lo = 1'b1; bus.wdata = 32'h99;
        end
        sb.push_back({ehi, elo});
        #1;
        chk("stall_at_start", {63'd0, bus.stall}, {63'd0, md_use});
        tick();
        bus.start = 1'b0; bus.mt_lo = 1'b0;
        busy_cnt = 0; done_at = 0; stall_bad = 0;
        for (int k = 1; k <= 60 && done_at == 0; k++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.stall !== (md_use & bus.busy)) stall_bad++;
            if (bus.done === 1'b1) done_at = k;
            bus.flush = flush_mid && (k == 2);
            bus.mt_hi = mt_mid && (k == 2);
            bus.wdata = 32'h5;
            tick();
        end
        bus.flush = 1'b0; bus.mt_hi = 1'b0;
        if (done_at == 0) begin
            total++; bad++;
            $display("FAIL done_timeout actual=none required=cycle %0d", lat);
        end
        chk("busy_cycles", 64'(busy_cnt), 64'(lat));
        chk("done_cycle", 64'(done_at), 64'(lat));
        chk("stall_run", 64'(stall_bad), 64'd0);
        chk("done_one_pulse", {63'd0, bus.done}, 64'd0);
        chk("stall_after", {63'd0, bus.stall}, 64'd0);
        exp = sb.pop_front();
        chk("hi", {32'd0, bus.hi}, {32'd0, exp[63:32]});
        chk("lo", {32'd0, bus.lo}, {32'd0, exp[31:0]});
        bus.md_use_d = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2,          c_MLAT, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,          c_MLAT, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          c_DLAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd3, 32'd7,         32'd2,          c_DLAT, 32'h0000_0001, 32'h0000_0003};
        vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  c_DLAT, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{3'd0, 32'h8000_0000, 32'h8000_0000,  c_MLAT, 32'h4000_0000, 32'h0000_0000};
        vecs[6] = '{3'd1, 32'h1234_5678, 32'h10,         c_MLAT, 32'h0000_0001, 32'h2345_6780};
        vecs[7] = '{3'd2, 32'd7,         32'hFFFF_FFFE,  c_DLAT, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8] = '{3'd3, 32'hFFFF_FFFF, 32'h10,         c_DLAT, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[9] = '{3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB,  c_MLAT, 32'h0000_0000, 32'h0000_000F};

        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.mt_hi = 0; bus.mt_lo = 0;
        bus.wdata = 0; bus.flush = 0; bus.md_use_d = 0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_stall", {63'd0, bus.stall}, 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);

        // Arithmetic vectors, alternating D-stage HI/LO use
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, 1'(i % 2),
                   0, 0, 0, vecs[i].ehi, vecs[i].elo);

        // mthi/mtlo then divide by zero leaves HI/LO untouched
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        chk("mt_hilo", {bus.hi, bus.lo}, {32'h11, 32'h22});
        run_op(3'd3, 32'd7, 32'd0, c_DLAT, 1'b1, 0, 0, 0, 32'h11, 32'h22);

        // start together with mtlo: start wins, mtlo dropped
        run_op(3'd3, 32'd7, 32'd0, c_DLAT, 1'b0, 0, 0, 1, 32'h11, 32'h22);

        // Flushed start and flushed mt are both ignored
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd3;
        bus.flush = 1'b1; bus.mt_hi = 1'b1; bus.wdata = 32'hAA; bus.md_use_d = 1'b1;
        #1;
        chk("flush_stall", {63'd0, bus.stall}, 64'd0);
        tick();
        bus.start = 0; bus.flush = 0; bus.mt_hi = 0; bus.md_use_d = 0;
        chk("flush_busy", {63'd0, bus.busy}, 64'd0);
        tick();
        chk("flush_busy2", {63'd0, bus.busy}, 64'd0);
        chk("flush_hilo", {bus.hi, bus.lo}, {32'h11, 32'h22});

        // Flush during RUN and mthi during RUN do not disturb the op
        run_op(3'd1, 32'd6, 32'd7, c_MLAT, 1'b1, 1, 0, 0, 32'd0, 32'd42);
        run_op(3'd3, 32'd100, 32'd7, c_DLAT, 1'b0, 0, 1, 0, 32'd2, 32'd14);

        // Undefined ops are ignored: no busy, no stall, HI/LO unchanged
        for (int u = 5; u <= 7; u++) begin
`ifdef MDU_MADD_EN
            if (u == 5) continue;
`endif
            bus.start = 1'b1; bus.op = 3'(u); bus.md_use_d = 1'b1;
            #1;
            chk("bad_op_stall", {63'd0, bus.stall}, 64'd0);
            tick();
            bus.start = 1'b0; bus.md_use_d = 1'b0;
            chk("bad_op_busy", {63'd0, bus.busy}, 64'd0);
            chk("bad_op_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});
        end

`ifdef MDU_MADD_EN
        mt(1'b1, 1'b1, 32'd0);
        mt(1'b0, 1'b1, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd1, 32'd1, c_MLAT, 1'b1, 0, 0, 0, 32'd1, 32'd0);
        run_op(3'd4, 32'hFFFF_FFFF, 32'd1, c_MLAT, 1'b0, 0, 0, 0, 32'd0, 32'hFFFF_FFFF);
`endif

        // Reset in RUN cycle 3 of a divide aborts it and clears HI/LO
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        begin
            int dcnt, bcnt;
            dcnt = 0; bcnt = 0;
            for (int k = 0; k < 15; k++) begin
                if (bus.done === 1'b1) dcnt++;
                if (bus.busy === 1'b1) bcnt++;
                tick();
            end
            chk("abort_no_done", 64'(dcnt), 64'd0);
            chk("abort_no_busy", 64'(bcnt), 64'd0);
            chk("abort_hilo_end", {bus.hi, bus.lo}, 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Multiply/divide sequencer for the E stage of the 5-stage pipeline.
- Accepts MDU ops from E, latches operands, and counts a fixed latency before committing HI/LO.
- Drives the D-stage stall for HI/LO-dependent instructions.
- Honors the exception/interrupt flush so a cancelled E-stage op never starts.

Parameters:
- MULT_LAT, 5, cycles from accepted mult/multu to HI/LO commit (>=1)
- DIV_LAT, 10, cycles from accepted div/divu to HI/LO commit (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  E-stage instruction is an MDU op
- op  in  3  0=mult 1=multu 2=div 3=divu; 4=madd 5=maddu (macro only); others = no-op
- a  in  32  rs operand
- b  in  32  rt operand
- mt_hi  in  1  mthi in E
- mt_lo  in  1  mtlo in E
- wdata  in  32  mthi/mtlo data
- flush  in  1  exception/interrupt taken this cycle; cancels E-stage start/mt
- md_use_d  in  1  D-stage instr is mult/div/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in flight
- stall  out  1  freeze PC/D, bubble E
- hi  out  32  HI register
- lo  out  32  LO register
- done  out  1  one-cycle pulse on the commit cycle

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous, active-high.
- Reset: state IDLE, counter=0, busy=0, done=0, hi=0, lo=0. Reset mid-operation aborts the op, leaves no commit, and still clears hi/lo.
- States: IDLE, RUN.
- Accept: in IDLE, start=1 and flush=0 at edge T:
  - latch op/a/b and load counter with LAT-1 (MULT_LAT for ops 0/1/4/5, DIV_LAT for 2/3);
  - go to RUN.
- Invalid or cancelled starts:
  - start with an undefined op is ignored and stays in IDLE;
  - start while in RUN is ignored (the pipeline guarantees it cannot occur, since stall is high).
- RUN:
  - busy=1;
  - counter decrements each cycle;
  - in the cycle counter==0, done=1, HI/LO are written at that edge, and the next state is IDLE.
- Timing: op accepted at edge T gives busy=1 for cycles T+1..T+LAT, done=1 in cycle T+LAT, and new hi/lo visible from T+LAT+1.
- Flush:
  - with flush=1, start, mt_hi and mt_lo are all ignored that cycle;
  - an op already in RUN is NOT cancelled and completes normally.
- mthi/mtlo:
  - in IDLE with flush=0, mt_hi writes hi<=wdata and mt_lo writes lo<=wdata at the edge;
  - ignored in RUN;
  - start and mt asserted together: start wins and mt is dropped.
- Arithmetic:
  - mult: signed 64-bit product; multu: unsigned; {hi,lo}<=product.
  - div: signed, quotient truncated toward zero, remainder takes the dividend's sign; lo<=quotient, hi<=remainder.
  - divu: unsigned.
  - div 0x80000000 / -1: lo=0x80000000, hi=0.
  - Divide by zero: hi/lo unchanged, timing unchanged (done still pulses).
- Stall (combinational): stall = md_use_d & (busy | (start & ~flush & op valid)).
- Outputs: hi/lo are registered outputs. done, busy and stall are glitch-free functions of registered state plus the above inputs (stall only).

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 4 (madd) gives {hi,lo} <= {hi,lo} + signed(a)*signed(b); op 5 (maddu) uses unsigned operands;
  - the accumulate sums the 64-bit product with the HI/LO value at commit time, modulo 2^64;
  - latency MULT_LAT.
- Undefined: ops 4/5 are treated as undefined and ignored (no busy, no stall, hi/lo unchanged).

Test Plan:
- Reset, then mult a=0xFFFFFFFF b=2 -> busy for 5 cycles, done in cycle 5, then hi=0xFFFFFFFF lo=0xFFFFFFFE; multu with same operands -> hi=0x00000001 lo=0xFFFFFFFE.
- div a=-7 b=2 -> busy 10 cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF; divu a=7 b=0 after mthi 0x11/mtlo 0x22 -> done pulses, hi=0x11 lo=0x22.
- start with flush=1 -> busy stays 0, hi/lo unchanged. flush mid-RUN -> commit still occurs on schedule.
- md_use_d=1 while start (valid op, no flush) and throughout RUN -> stall=1 from start cycle through cycle T+LAT, then 0; md_use_d=0 -> stall=0 throughout.
- reset at RUN cycle 3 of a div -> next cycle busy=0, done never pulses, hi=lo=0; mt_hi with wdata=0x5 during RUN -> ignored.
- MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, maddu a=1 b=1 -> hi=1 lo=0 after 5 cycles; macro undefined -> op 5 ignored.
